// File: rtl/reg_wr_arbiter.sv
// Register-file write arbiter: core writeback vs. debug writes, with
// starvation boost for the debug port and a sequenced x1..x31 clear.
module reg_wr_arbiter #(
   parameter int unsigned STARVE_LIMIT = 4
) (
   input  logic        i_clk,
   input  logic        i_rst_n,
   input  logic        i_req0_valid,
   output logic        o_req0_ready,
   input  logic [4:0]  i_req0_addr,
   input  logic [31:0] i_req0_data,
   input  logic        i_req1_valid,
   output logic        o_req1_ready,
   input  logic [4:0]  i_req1_addr,
   input  logic [31:0] i_req1_data,
   input  logic        i_clr_start,
   output logic        o_rd_wren,
   output logic [4:0]  o_rd_addr,
   output logic [31:0] o_rd_data,
   output logic        o_busy,
   output logic        o_clr_done
);

   typedef enum logic {IDLE, CLEAR} state_t;

   state_t     state_q, state_d;
   logic [3:0] starve_q;
   logic       boost;
   logic       xfer0, xfer1;
   logic       in_idle;

   assign in_idle = (state_q == IDLE);
   assign boost   = (starve_q == 4'(STARVE_LIMIT));
   assign xfer0   = i_req0_valid & o_req0_ready;
   assign xfer1   = i_req1_valid & o_req1_ready;

   // Readies are gated by reset so nothing is accepted while held in reset.
   always_comb begin
      o_req0_ready = 1'b0;
      o_req1_ready = 1'b0;
      if (i_rst_n && in_idle && !i_clr_start) begin
         if (boost) begin
            o_req1_ready = 1'b1;
         end else begin
            o_req0_ready = 1'b1;
            o_req1_ready = !i_req0_valid;
         end
      end
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         IDLE:  if (i_clr_start) state_d = CLEAR;
         CLEAR: if (o_rd_addr == 5'd31) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) state_q <= IDLE;
      else          state_q <= state_d;
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         starve_q <= 4'd0;
      end else if (in_idle) begin
         if (xfer1)
            starve_q <= 4'd0;
         else if (i_req1_valid && !o_req1_ready && !boost)
            starve_q <= starve_q + 4'd1;
      end
   end

   // The output address register doubles as the clear sequence counter.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         o_rd_wren <= 1'b0;
         o_rd_addr <= 5'd0;
         o_rd_data <= 32'd0;
      end else if (in_idle) begin
         if (i_clr_start) begin
            o_rd_wren <= 1'b1;
            o_rd_addr <= 5'd1;
            o_rd_data <= 32'd0;
         end else if (xfer0) begin
            o_rd_wren <= (i_req0_addr != 5'd0);
            o_rd_addr <= i_req0_addr;
            o_rd_data <= i_req0_data;
         end else if (xfer1) begin
            o_rd_wren <= (i_req1_addr != 5'd0);
            o_rd_addr <= i_req1_addr;
            o_rd_data <= i_req1_data;
         end else begin
            o_rd_wren <= 1'b0;
         end
      end else if (o_rd_addr == 5'd31) begin
         o_rd_wren <= 1'b0;
      end else begin
         o_rd_wren <= 1'b1;
         o_rd_addr <= o_rd_addr + 5'd1;
         o_rd_data <= 32'd0;
      end
   end

   assign o_busy     = (state_q == CLEAR);
   assign o_clr_done = o_busy && (o_rd_addr == 5'd31);

endmodule

// File: tb/tb_reg_wr_arbiter.sv
// Directed bench for reg_wr_arbiter: priority, starve boost, addr-0 writes,
// clear sequence, clear during clear, and reset mid-clear.
module tb_reg_wr_arbiter;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        v0 = 1'b0, v1 = 1'b0, clr = 1'b0;
   logic        r0, r1;
   logic [4:0]  a0 = 5'd0, a1 = 5'd0;
   logic [31:0] d0 = 32'd0, d1 = 32'd0;
   logic        wren, busy, done;
   logic [4:0]  waddr;
   logic [31:0] wdata;

   int checks = 0;
   int failures = 0;
   int writes;

   always #5 clk = ~clk;

   reg_wr_arbiter #(.STARVE_LIMIT(4)) dut (
      .i_clk(clk), .i_rst_n(rst_n),
      .i_req0_valid(v0), .o_req0_ready(r0),
      .i_req0_addr(a0), .i_req0_data(d0),
      .i_req1_valid(v1), .o_req1_ready(r1),
      .i_req1_addr(a1), .i_req1_data(d1),
      .i_clr_start(clr),
      .o_rd_wren(wren), .o_rd_addr(waddr), .o_rd_data(wdata),
      .o_busy(busy), .o_clr_done(done)
   );

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   initial begin
      // reset state, readies low even with a request pending
      v0 = 1'b1; a0 = 5'd5; d0 = 32'hDEADBEEF;
      #2;
      chk("rst_wren", 32'(wren), 0);
      chk("rst_addr", 32'(waddr), 0);
      chk("rst_data", wdata, 0);
      chk("rst_busy", 32'(busy), 0);
      chk("rst_done", 32'(done), 0);
      chk("rst_r0", 32'(r0), 0);
      chk("rst_r1", 32'(r1), 0);
      step();
      chk("rst_hold_wren", 32'(wren), 0);
      rst_n = 1'b1;
      #1;
      chk("rel_r0", 32'(r0), 1);
      step();
      chk("w5_wren", 32'(wren), 1);
      chk("w5_addr", 32'(waddr), 5);
      chk("w5_data", wdata, 32'hDEADBEEF);
      v0 = 1'b0;
      step();
      chk("idle_wren", 32'(wren), 0);
      chk("idle_addr_hold", 32'(waddr), 5);

      // 4:1 fairness with both requesters valid continuously
      v0 = 1'b1; a0 = 5'd2; d0 = 32'h000000A0;
      v1 = 1'b1; a1 = 5'd3; d1 = 32'h000000B1;
      for (int i = 0; i < 10; i++) begin
         #1;
         chk($sformatf("fair_r0_%0d", i), 32'(r0), (i % 5 == 4) ? 1'b0 : 1'b1);
         chk($sformatf("fair_r1_%0d", i), 32'(r1), (i % 5 == 4) ? 1'b1 : 1'b0);
         step();
         chk($sformatf("fair_addr_%0d", i), 32'(waddr),
             (i % 5 == 4) ? 32'd3 : 32'd2);
         chk($sformatf("fair_data_%0d", i), wdata,
             (i % 5 == 4) ? 32'hB1 : 32'hA0);
      end
      v0 = 1'b0; v1 = 1'b0;
      step();

      // requester 1 writes x0: handshake completes, no write strobe
      v1 = 1'b1; a1 = 5'd0; d1 = 32'h1234;
      #1;
      chk("a0_r1", 32'(r1), 1);
      step();
      chk("a0_wren", 32'(wren), 0);
      v1 = 1'b0;
      step();
      chk("a0_after_wren", 32'(wren), 0);

      // clear with req0 waiting, plus a stray clr_start mid-clear
      clr = 1'b1; v0 = 1'b1; a0 = 5'd7; d0 = 32'h77;
      #1;
      chk("clr_prec_r0", 32'(r0), 0);
      chk("clr_prec_r1", 32'(r1), 0);
      step();
      clr = 1'b0;
      writes = 0;
      for (int i = 1; i <= 31; i++) begin
         if (i == 10) clr = 1'b1;
         if (i == 11) clr = 1'b0;
         #1;
         if (wren) writes++;
         chk($sformatf("clr_addr_%0d", i), 32'(waddr), i);
         chk($sformatf("clr_data_%0d", i), wdata, 0);
         chk($sformatf("clr_busy_%0d", i), 32'(busy), 1);
         chk($sformatf("clr_r0_%0d", i), 32'(r0), 0);
         chk($sformatf("clr_done_%0d", i), 32'(done), (i == 31) ? 1 : 0);
         step();
      end
      #1;
      chk("clr_writes", 32'(writes), 31);
      chk("post_clr_wren", 32'(wren), 0);
      chk("post_clr_busy", 32'(busy), 0);
      chk("post_clr_done", 32'(done), 0);
      chk("post_clr_r0", 32'(r0), 1);
      step();
      chk("post_clr_xfer_wren", 32'(wren), 1);
      chk("post_clr_xfer_addr", 32'(waddr), 7);
      chk("post_clr_xfer_data", wdata, 32'h77);
      v0 = 1'b0;
      step();

      // reset during the 10th clear cycle aborts the sequence
      clr = 1'b1;
      step();
      clr = 1'b0;
      repeat (9) step();
      chk("mid_addr", 32'(waddr), 10);
      chk("mid_busy", 32'(busy), 1);
      #2;
      rst_n = 1'b0;
      #1;
      chk("mid_rst_wren", 32'(wren), 0);
      chk("mid_rst_addr", 32'(waddr), 0);
      chk("mid_rst_busy", 32'(busy), 0);
      step();
      rst_n = 1'b1;
      for (int i = 0; i < 3; i++) begin
         step();
         chk($sformatf("abort_wren_%0d", i), 32'(wren), 0);
         chk($sformatf("abort_busy_%0d", i), 32'(busy), 0);
      end
      v1 = 1'b1; a1 = 5'd9; d1 = 32'h99;
      step();
      chk("rr_wren", 32'(wren), 1);
      chk("rr_addr", 32'(waddr), 9);
      chk("rr_data", wdata, 32'h99);
      v1 = 1'b0;
      step();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/reg_wr_arbiter.md
REG_WR_ARBITER -- requirements
Module: reg_wr_arbiter

Interface
REQ-001 SHALL have parameter STARVE_LIMIT, default 4, meaning consecutive lost cycles before requester 1 is force-granted (range 1..15).
REQ-002 SHALL have port i_clk, input, 1, the single clock; all state changes on its rising edge.
REQ-003 SHALL have port i_rst_n, input, 1, asynchronous active-low reset.
REQ-004 SHALL have ports i_req0_valid/o_req0_ready, in/out, 1 each, core writeback handshake.
REQ-005 SHALL have ports i_req0_addr, input, 5, and i_req0_data, input, 32, core write address and data.
REQ-006 SHALL have ports i_req1_valid/o_req1_ready, in/out, 1 each, debug/external write handshake.
REQ-007 SHALL have ports i_req1_addr, input, 5, and i_req1_data, input, 32, debug write address and data.
REQ-008 SHALL have port i_clr_start, input, 1, request to zero registers x1..x31.
REQ-009 SHALL have ports o_rd_wren, output, 1; o_rd_addr, output, 5; o_rd_data, output, 32: the register-file write port.
REQ-010 SHALL have ports o_busy, output, 1, clear in progress, and o_clr_done, output, 1, one-cycle clear-complete pulse.

Function
REQ-011 SHALL implement FSM states IDLE and CLEAR; IDLE -> CLEAR when i_clr_start=1 in IDLE; CLEAR -> IDLE after the write of x31 is presented.
REQ-012 SHALL define a transfer as valid=1 and ready=1 on the same rising edge; requesters hold valid/addr/data stable until transfer.
REQ-013 SHALL in IDLE without boost and without i_clr_start drive o_req0_ready=1 and o_req1_ready=!i_req0_valid (requester 0 fixed priority).
REQ-014 SHALL keep a saturating starve counter: +1 each IDLE cycle with i_req1_valid=1 and o_req1_ready=0; cleared on a requester-1 transfer; saturates at STARVE_LIMIT.
REQ-015 SHALL, when starve counter = STARVE_LIMIT (boost) in IDLE, drive o_req0_ready=0, o_req1_ready=1.
REQ-016 SHALL present a transferred write registered: transfer on edge N -> o_rd_wren=1, o_rd_addr/o_rd_data = transferred values during cycle N+1 only.
REQ-017 SHALL accept writes to address 0 normally (handshake completes) but keep o_rd_wren=0 for them.
REQ-018 SHALL drive o_rd_wren=0 in any cycle following an edge without a transfer or clear write; o_rd_addr/o_rd_data then hold last value.
REQ-019 SHALL give i_clr_start precedence: in an IDLE cycle with i_clr_start=1 both readies are 0 and no transfer occurs.
REQ-020 SHALL, in CLEAR, present o_rd_wren=1, o_rd_data=0, o_rd_addr=1,2,...,31 in the 31 consecutive cycles following the start edge.
REQ-021 SHALL hold o_busy=1 and both readies 0 for exactly those 31 cycles; o_clr_done=1 only in the cycle presenting address 31.
REQ-022 SHALL ignore i_clr_start while in CLEAR; starve counter holds its value during CLEAR.
REQ-023 SHALL permit the next transfer in the cycle immediately after the address-31 cycle.

Reset
REQ-024 SHALL on i_rst_n=0, immediately and asynchronously, force state IDLE, starve counter 0, o_rd_wren=0, o_rd_addr=0, o_rd_data=0, o_busy=0, o_clr_done=0.
REQ-025 SHALL, if reset asserts mid-CLEAR, abort the clear (no further writes) and resume in IDLE after release.
REQ-026 SHALL keep readies 0 while i_rst_n=0 and accept first transfer on the first rising edge after release.

Verification
REQ-027 SHALL cover: req0 valid addr=5 data=0xDEADBEEF alone -> ready0=1, next cycle o_rd_wren=1, addr=5, data=0xDEADBEEF.
REQ-028 SHALL cover: req0 and req1 valid continuously, STARVE_LIMIT=4 -> four req0 transfers, then one req1 transfer, pattern repeats 4:1.
REQ-029 SHALL cover: req1 write addr=0 data=0x1234 -> handshake completes, o_rd_wren stays 0.
REQ-030 SHALL cover: i_clr_start pulse with req0 valid -> 31 zero writes x1..x31, o_clr_done with x31, req0 transfers the cycle after.
REQ-031 SHALL cover: i_rst_n low at 10th clear cycle -> outputs 0 immediately, no writes after release until a new transfer.
REQ-032 SHALL cover: i_clr_start asserted during CLEAR -> ignored, exactly 31 writes total.
